// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between EXU and a req/ack data bus.
// Optional WAIT-state timeout fault is built only when LSU_TIMEOUT_EN is defined.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [3:0]  rmask,
  input  logic [3:0]  wmask,
  input  logic        ld_signed,
  input  logic [4:0]  rd_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [1:0]  fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] F_OK       = 2'b00;
  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_BUSERR   = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  r_fault;
  logic        r_is_load;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_rmask;
  logic        r_signed;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;

  logic        w_req;
  logic        w_wait;
  logic [3:0]  w_mask;
  logic        w_aligned;
  logic [1:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_ld_data;

`ifdef LSU_TIMEOUT_EN
  localparam logic [1:0]       F_TIMEOUT = 2'b11;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo;
  assign w_tmo = (r_cnt == TMO_LAST);

  // Held at zero outside WAIT so every access starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else if (!bus_ack)          r_cnt <= r_cnt + 1'b1;
  end
`else
  logic [CNT_W-1:0] w_unused_tmo;
  assign w_unused_tmo = CNT_W'(TIMEOUT_CYCLES);
`endif

  // rst_n term keeps stall at 0 while reset is held, even with a request present.
  assign w_req  = rst_n & ex_valid & (rd_en | wr_en);
  assign w_wait = (r_state == S_WAIT);

  always_comb begin
    w_mask    = rd_en ? rmask : wmask;
    w_aligned = 1'b0;
    case (w_mask)
      4'b1111:                            w_aligned = (mem_addr[1:0] == 2'b00);
      4'b0011, 4'b1100:                   w_aligned = ~mem_addr[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_aligned = 1'b1;
      default:                            w_aligned = 1'b0;
    endcase
  end

  always_comb begin
    w_shift = 2'd0;
    casez (r_rmask)
      4'b???1: w_shift = 2'd0;
      4'b??10: w_shift = 2'd1;
      4'b?100: w_shift = 2'd2;
      4'b1000: w_shift = 2'd3;
      default: w_shift = 2'd0;
    endcase
    w_shifted = bus_rdata >> {w_shift, 3'b000};
    case (r_rmask)
      4'b1111:          w_ld_data = w_shifted;
      4'b0011, 4'b1100: w_ld_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:          w_ld_data = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_fault   <= F_OK;
      r_is_load <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rmask   <= '0;
      r_signed  <= 1'b0;
      r_rd      <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (!w_aligned) begin
              r_state <= S_FAULT;
              r_fault <= F_MISALIGN;
            end else begin
              r_state   <= S_WAIT;
              r_is_load <= rd_en;
              r_addr    <= mem_addr[31:2];
              r_wdata   <= rd_en ? '0 : mem_wdata;
              r_wstrb   <= rd_en ? '0 : wmask;
              r_rmask   <= rmask;
              r_signed  <= ld_signed;
              r_rd      <= rd_addr;
            end
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            if (bus_err) begin
              r_state <= S_FAULT;
              r_fault <= F_BUSERR;
            end else begin
              r_state <= S_DONE;
              if (r_is_load) r_wb_data <= w_ld_data;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_tmo) begin
            r_state <= S_FAULT;
            r_fault <= F_TIMEOUT;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req   = w_wait;
  assign bus_we    = w_wait & ~r_is_load;
  assign bus_addr  = w_wait ? {r_addr, 2'b00} : '0;
  assign bus_wdata = w_wait ? r_wdata : '0;
  assign bus_wstrb = w_wait ? r_wstrb : '0;

  assign stall    = w_wait | (r_state == S_FAULT) | ((r_state == S_IDLE) & w_req);
  assign wb_valid = (r_state == S_DONE) & r_is_load;
  assign wb_addr  = wb_valid ? r_rd : '0;
  assign wb_data  = wb_valid ? r_wb_data : '0;
  assign fault    = r_fault;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: transaction-level reference model compared every cycle,
// plus directed vectors with hand-computed literal checks.
module tb_lsu_ctrl;

  localparam int TB_TMO = 4;

  logic        clk, rst_n;
  logic        ex_valid, rd_en, wr_en, ld_signed;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  rmask, wmask;
  logic [4:0]  rd_addr;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        stall, wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  fault;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TB_TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rd_en(rd_en), .wr_en(wr_en), .rmask(rmask),
    .wmask(wmask), .ld_signed(ld_signed), .rd_addr(rd_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .stall(stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_extract(input logic [31:0] d, input logic [3:0] m, input logic s);
    int lo = 0, pc = 0;
    longint unsigned v, msk;
    for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
    for (int i = 0; i < 4; i++) if (m[i]) pc++;
    msk = (64'd1 << (8 * pc)) - 64'd1;
    v = (longint'(d) >> (8 * lo)) & msk;
    if (s && pc != 0 && v[8 * pc - 1]) v = v | ~msk;
    return v[31:0];
  endfunction

  function automatic bit m_aligned(input logic [31:0] a, input logic [3:0] m);
    int lo = 0, pc = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
    for (int i = 0; i < 4; i++) if (m[i]) pc++;
    if (pc == 1) return 1'b1;
    if (pc == 2) return (lo == 0 || lo == 2) && (m == (4'b0011 << lo)) && (a % 2 == 0);
    if (pc == 4) return (a % 4 == 0);
    return 1'b0;
  endfunction

  logic        m_busy, m_done, m_dead, m_load, m_we, m_sgn;
  logic [1:0]  m_fault;
  logic [31:0] m_addr, m_wdata, m_wbd;
  logic [3:0]  m_wstrb, m_rmask;
  logic [4:0]  m_rd;
  int          m_wcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_dead <= 0; m_load <= 0; m_we <= 0; m_sgn <= 0;
      m_fault <= 2'b00; m_addr <= '0; m_wdata <= '0; m_wbd <= '0;
      m_wstrb <= '0; m_rmask <= '0; m_rd <= '0; m_wcnt <= 0;
    end else if (m_dead) begin
      m_dead <= 1'b1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (bus_ack) begin
        m_busy <= 1'b0;
        if (bus_err) begin
          m_dead <= 1'b1; m_fault <= 2'b10;
        end else begin
          m_done <= 1'b1;
          if (m_load) m_wbd <= m_extract(bus_rdata, m_rmask, m_sgn);
        end
      end
`ifdef LSU_TIMEOUT_EN
      else if (m_wcnt + 1 >= TB_TMO) begin
        m_busy <= 1'b0; m_dead <= 1'b1; m_fault <= 2'b11;
      end else m_wcnt <= m_wcnt + 1;
`endif
    end else if (ex_valid && (rd_en || wr_en)) begin
      if (!m_aligned(mem_addr, rd_en ? rmask : wmask)) begin
        m_dead <= 1'b1; m_fault <= 2'b01;
      end else begin
        m_busy  <= 1'b1;
        m_load  <= rd_en;
        m_we    <= !rd_en;
        m_addr  <= mem_addr;
        m_wdata <= rd_en ? 32'd0 : mem_wdata;
        m_wstrb <= rd_en ? 4'd0 : wmask;
        m_rmask <= rmask;
        m_sgn   <= ld_signed;
        m_rd    <= rd_addr;
        m_wcnt  <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        x_wbv, x_stall;
    logic [31:0] x_addr;
    x_addr  = m_busy ? {m_addr[31:2], 2'b00} : 32'd0;
    x_stall = m_dead | m_busy | (rst_n & !m_done & ex_valid & (rd_en | wr_en));
    x_wbv   = m_done & m_load;
    chk("m_bus_req",   32'(bus_req),   32'(m_busy));
    chk("m_bus_we",    32'(bus_we),    32'(m_busy & m_we));
    chk("m_bus_addr",  bus_addr,       x_addr);
    chk("m_bus_wdata", bus_wdata,      m_busy ? m_wdata : 32'd0);
    chk("m_bus_wstrb", 32'(bus_wstrb), m_busy ? 32'(m_wstrb) : 32'd0);
    chk("m_stall",     32'(stall),     32'(x_stall));
    chk("m_wb_valid",  32'(wb_valid),  32'(x_wbv));
    chk("m_wb_addr",   32'(wb_addr),   x_wbv ? 32'(m_rd) : 32'd0);
    chk("m_wb_data",   wb_data,        x_wbv ? m_wbd : 32'd0);
    chk("m_fault",     32'(fault),     32'(m_fault));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle(); @(posedge clk); #1; endtask
  task automatic sample();     @(negedge clk);     endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] rm, input logic [3:0] wm, input logic sg, input logic [4:0] ra);
    ex_valid = 1'b1; rd_en = rd; wr_en = wr; mem_addr = a; mem_wdata = wd;
    rmask = rm; wmask = wm; ld_signed = sg; rd_addr = ra;
  endtask

  task automatic clr_req();
    ex_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    rmask = '0; wmask = '0; ld_signed = 1'b0; rd_addr = '0;
  endtask

  task automatic ack(input logic a, input logic e, input logic [31:0] d);
    bus_ack = a; bus_err = e; bus_rdata = d;
  endtask

  task automatic rst_pulse();
    clr_req(); ack(0, 0, '0);
    rst_n = 1'b0;
    sample(); chk("rstp_stall", 32'(stall), 32'd0); chk("rstp_fault", 32'(fault), 32'd0);
    next_cycle(); rst_n = 1'b1;
    sample(); chk("rstp_post_stall", 32'(stall), 32'd0); chk("rstp_post_fault", 32'(fault), 32'd0);
  endtask

  // Single-access load with ack on the first WAIT cycle; returns writeback data.
  task automatic quick_load(input logic [31:0] a, input logic [3:0] rm, input logic sg,
                            input logic [31:0] rdata, output logic [31:0] got);
    next_cycle(); req(1, 0, a, '0, rm, '0, sg, 5'd9);
    next_cycle(); clr_req(); ack(1, 0, rdata);
    next_cycle(); ack(0, 0, '0);
    sample(); got = wb_data;
    chk("ql_wb_valid", 32'(wb_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; clr_req(); ack(0, 0, '0);
    repeat (2) @(posedge clk);
    sample();
    chk("rst_bus_req", 32'(bus_req), 32'd0); chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0); chk("rst_fault", 32'(fault), 32'd0);
    next_cycle(); rst_n = 1'b1;

    // LW 0x100, ack at cycle 3
    next_cycle(); req(1, 0, 32'h100, '0, 4'hF, '0, 0, 5'd3);
    sample(); chk("lw_c0_stall", 32'(stall), 32'd1); chk("lw_c0_req", 32'(bus_req), 32'd0);
    next_cycle(); clr_req();
    sample(); chk("lw_c1_req", 32'(bus_req), 32'd1); chk("lw_c1_addr", bus_addr, 32'h100);
    next_cycle();
    next_cycle(); ack(1, 0, 32'hDEADBEEF);
    sample(); chk("lw_c3_req", 32'(bus_req), 32'd1);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("lw_c4_wbv", 32'(wb_valid), 32'd1); chk("lw_c4_data", wb_data, 32'hDEADBEEF);
    chk("lw_c4_wba", 32'(wb_addr), 32'd3); chk("lw_c4_stall", 32'(stall), 32'd0);
    chk("lw_c4_req", 32'(bus_req), 32'd0);
    next_cycle(); sample(); chk("lw_c5_wbv", 32'(wb_valid), 32'd0);

    // LB at 0x103 signed / unsigned
    quick_load(32'h103, 4'b1000, 1, 32'h80123456, d); chk("lb_signed", d, 32'hFFFFFF80);
    quick_load(32'h103, 4'b1000, 0, 32'h80123456, d); chk("lb_unsigned", d, 32'h00000080);
    // load priority when rd_en and wr_en both set
    next_cycle(); req(1, 1, 32'h300, 32'hCAFEF00D, 4'b0001, 4'hF, 1, 5'd7);
    next_cycle(); clr_req(); ack(1, 0, 32'h000000F0);
    sample(); chk("both_we", 32'(bus_we), 32'd0); chk("both_wstrb", 32'(bus_wstrb), 32'd0);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("both_data", wb_data, 32'hFFFFFFF0);

    // LH at 0x102 held through DONE: not accepted in DONE, re-accepted next IDLE
    next_cycle(); req(1, 0, 32'h102, '0, 4'b1100, '0, 1, 5'd5);
    next_cycle(); ack(1, 0, 32'hBEEF1234);
    sample(); chk("lh_addr", bus_addr, 32'h100);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("lh_data", wb_data, 32'hFFFFBEEF); chk("lh_done_stall", 32'(stall), 32'd0);
    next_cycle();
    sample(); chk("lh_reacc_stall", 32'(stall), 32'd1); chk("lh_reacc_req", 32'(bus_req), 32'd0);
    next_cycle(); clr_req(); ack(1, 0, 32'h7FFF0000);
    sample(); chk("lh2_req", 32'(bus_req), 32'd1);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("lh2_data", wb_data, 32'h00007FFF);

    // SW 0x204, zero-wait ack
    next_cycle(); req(0, 1, 32'h204, 32'h12345678, '0, 4'hF, 0, 5'd0);
    next_cycle(); clr_req(); ack(1, 0, '0);
    sample(); chk("sw_we", 32'(bus_we), 32'd1); chk("sw_wstrb", 32'(bus_wstrb), 32'hF);
    chk("sw_addr", bus_addr, 32'h204); chk("sw_wdata", bus_wdata, 32'h12345678);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("sw_wbv", 32'(wb_valid), 32'd0); chk("sw_stall", 32'(stall), 32'd0);

    // SB 0x205 lane 1, ack on second WAIT cycle
    next_cycle(); req(0, 1, 32'h205, 32'h0000AB00, '0, 4'b0010, 0, 5'd0);
    next_cycle(); clr_req();
    next_cycle(); ack(1, 0, '0);
    sample(); chk("sb_addr", bus_addr, 32'h204); chk("sb_wstrb", 32'(bus_wstrb), 32'b0010);
    next_cycle(); ack(0, 0, '0);

    // long WAIT: timeout build faults after 4 WAIT cycles, default keeps waiting
    next_cycle(); req(1, 0, 32'h400, '0, 4'hF, '0, 0, 5'd1);
    next_cycle(); clr_req();
    next_cycle(); next_cycle();
    sample(); chk("lw_long_c3_req", 32'(bus_req), 32'd1);
    next_cycle(); next_cycle();
    sample();
`ifdef LSU_TIMEOUT_EN
    chk("tmo_fault", 32'(fault), 32'd3); chk("tmo_req", 32'(bus_req), 32'd0);
`else
    chk("notmo_fault", 32'(fault), 32'd0); chk("notmo_req", 32'(bus_req), 32'd1);
`endif
    next_cycle(); next_cycle(); ack(1, 0, 32'h11112222);
    next_cycle(); ack(0, 0, '0);
    next_cycle(); rst_pulse();

    // bus error
    next_cycle(); req(1, 0, 32'h500, '0, 4'hF, '0, 0, 5'd2);
    next_cycle(); clr_req();
    next_cycle(); ack(1, 1, 32'h0);
    next_cycle(); ack(0, 0, '0);
    sample(); chk("err_fault", 32'(fault), 32'd2); chk("err_stall", 32'(stall), 32'd1);
    chk("err_req", 32'(bus_req), 32'd0);
    next_cycle(); req(0, 1, 32'h0, 32'h1, '0, 4'hF, 0, 5'd0);
    next_cycle(); sample(); chk("err_noacc_req", 32'(bus_req), 32'd0);
    next_cycle(); rst_pulse();

    // misaligned word and non-contiguous mask
    next_cycle(); req(1, 0, 32'h102, '0, 4'hF, '0, 0, 5'd4);
    sample(); chk("mis_c0_stall", 32'(stall), 32'd1);
    next_cycle(); clr_req();
    sample(); chk("mis_fault", 32'(fault), 32'd1); chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd1);
    next_cycle(); rst_pulse();
    next_cycle(); req(0, 1, 32'h100, 32'h0, '0, 4'b0110, 0, 5'd0);
    next_cycle(); clr_req();
    sample(); chk("mis0110_fault", 32'(fault), 32'd1);
    next_cycle(); rst_pulse();

    // asynchronous reset in the middle of WAIT
    next_cycle(); req(1, 0, 32'h600, '0, 4'hF, '0, 0, 5'd6);
    next_cycle(); clr_req();
    next_cycle(); chk("arst_pre_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst_req", 32'(bus_req), 32'd0); chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_wbv", 32'(wb_valid), 32'd0);
    next_cycle(); rst_n = 1'b1;
    next_cycle(); sample(); chk("arst_idle_req", 32'(bus_req), 32'd0);
    quick_load(32'h702, 4'b1100, 0, 32'h80010000, d); chk("arst_after_lh", d, 32'h00008001);

    next_cycle(); next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog expired");
  end

endmodule
